// File: rtl/rib_ram_resp.sv
// rib_ram_resp
// Memory-side responder for the RIB data-memory port driven by the core's
// execute stage. It accepts one read or write at a time into an internal
// word array, inserts WAIT_CYCLES wait states, and holds the core stalled
// until the access completes.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  BUSY cycles inserted per access (0..15)
//
// Ports
//   clk      clock, all state updates on the rising edge
//   rst      synchronous active-low reset
//   req_i    access request                    (rib_ram_req)
//   we_i     1 = write, 0 = read               (rib_ram_we)
//   sel_i    byte-lane enables, bit n -> [8n+7:8n] (ram_sel)
//   addr_i   byte address                      (rib_ram_wraddr)
//   wdata_i  write data                        (rib_ram_wdata)
//   rdata_o  registered read data              (rib_ram_rdata)
//   hold_o   combinational stall to the core   (rib_hold_flag)
//   ack_o    one-cycle completion pulse
//   err_o    one-cycle out-of-range pulse
module rib_ram_resp #(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        hold_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  // Value loaded into the wait-state counter on accept; unused when there
  // are no wait states, guarded so it never underflows.
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        finish;

  // Access captured on the accept edge.
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Operands of the access being completed. With no wait states the
  // access completes on the accept edge itself, before the latched copies
  // exist, so the live inputs are used while still in IDLE.
  logic          acc_we;
  logic [3:0]    acc_sel;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_oor;

  logic [31:0] mem [DEPTH];

  assign acc_we    = (state == IDLE) ? we_i    : we_q;
  assign acc_sel   = (state == IDLE) ? sel_i   : sel_q;
  assign acc_addr  = (state == IDLE) ? addr_i  : addr_q;
  assign acc_wdata = (state == IDLE) ? wdata_i : wdata_q;

  assign acc_idx = acc_addr[AW+1:2];
  assign acc_oor = |acc_addr[31:AW+2];

  // The byte offset within a word is deliberately ignored.
  logic unused_byte_offset;
  assign unused_byte_offset = ^acc_addr[1:0];

  assign hold_o = rst && (((state == IDLE) && req_i) || (state == BUSY));

  // Next-state logic. finish marks the edge that enters DONE, which is
  // where the array access and the ack/err pulses happen.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_i) begin
          if (WAIT_CYCLES > 0) begin
            state_next = BUSY;
            cnt_next   = CNT_LOAD;
          end else begin
            state_next = DONE;
            finish     = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = DONE;
          finish     = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_o <= 32'd0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ack_o <= finish;
      err_o <= finish && acc_oor;
      if (finish) begin
        if (acc_oor) begin
          rdata_o <= 32'd0;
        end else if (!acc_we) begin
          rdata_o <= mem[acc_idx];
        end
      end
    end
  end

  // Request capture. These are pure datapath registers: they are only
  // consumed after an accept has loaded them, so they carry no reset.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_i) begin
      we_q    <= we_i;
      sel_q   <= sel_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  // Array write with per-lane enables. A reset on the commit edge aborts
  // the write.
  always_ff @(posedge clk) begin
    // NOTE: the array is never reset; its contents survive rst and only
    // change through completed writes.
    if (rst && finish && !acc_oor && acc_we) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_sel[n]) begin
          mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_rib_ram_resp.sv
// tb_rib_ram_resp
// Drives three responders (0, 1 and 3 wait states) with directed vectors,
// hand-written corner sequences and randomized traffic checked against a
// transaction-level reference model.
module tb_rib_ram_resp;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int N     = 3;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [N];
  logic        we    [N];
  logic [3:0]  sel   [N];
  logic [31:0] addr  [N];
  logic [31:0] wdata [N];
  logic [31:0] rdata [N];
  logic        hold  [N];
  logic        ack   [N];
  logic        err   [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    rib_ram_resp #(
      .DEPTH      (DEPTH),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .req_i  (req[g]),
      .we_i   (we[g]),
      .sel_i  (sel[g]),
      .addr_i (addr[g]),
      .wdata_i(wdata[g]),
      .rdata_o(rdata[g]),
      .hold_o (hold[g]),
      .ack_o  (ack[g]),
      .err_o  (err[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on responder k, starting in IDLE just after an edge. Returns
  // the number of cycles hold was high, the accept-to-ack distance in edges
  // (-1 on timeout), and err/rdata seen with the ack. Ends back in IDLE.
  task automatic access(input int k, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        output int hc, output int lat, output logic e,
                        output logic [31:0] r);
    req[k] = 1'b1; we[k] = w; sel[k] = s; addr[k] = a; wdata[k] = d;
    hc = 0; lat = -1; e = 1'b0; r = 32'd0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (hold[k]) hc++;
      @(posedge clk); #1;
      req[k] = 1'b0;  // dropped after the accept edge: must be ignored in BUSY
      if (ack[k]) begin
        lat = c; e = err[k]; r = rdata[k];
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Held-high request: completions must arrive every w+2 cycles.
  task automatic back_to_back(input int k);
    int w, prev, nacks;
    w = wait_of(k); prev = -1; nacks = 0;
    req[k] = 1'b1; we[k] = 1'b0; sel[k] = 4'hF; addr[k] = 32'h10;
    for (int c = 0; c < 4 * (w + 2) + 1; c++) begin
      @(negedge clk);
      if (ack[k]) begin
        if (prev >= 0) check($sformatf("b2b%0d gap", k), 32'(c - prev), 32'(w + 2));
        prev = c;
        nacks++;
      end
      @(posedge clk); #1;
    end
    req[k] = 1'b0;
    check($sformatf("b2b%0d acks", k), 32'(nacks), 32'd4);
    repeat (6) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model for randomized traffic ----------------
  int          remain   [N];   // edges left until DONE; 0 = not in flight
  bit          in_done  [N];
  logic        cwe      [N];
  logic [3:0]  csel     [N];
  logic [31:0] caddr    [N];
  logic [31:0] cwdata   [N];
  logic        exp_ack  [N];
  logic        exp_err  [N];
  logic [31:0] exp_rd   [N];
  bit          rd_known [N];
  logic [31:0] mm       [N][16];  // window: words 0..7 and DEPTH-8..DEPTH-1
  bit   [3:0]  mk       [N][16];  // lanes written since the model started

  function automatic logic [31:0] rand_addr();
    int s;
    logic [31:0] a;
    s = $urandom_range(0, 17);
    if (s < 8)       a = 32'(s * 4);
    else if (s < 16) a = 32'((DEPTH - 16 + s) * 4);
    else if (s == 16) a = 32'(DEPTH * 4 + $urandom_range(0, 255) * 4);
    else             a = $urandom | 32'h8000_0000;
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  task automatic model_perform(input int k);
    bit oor;
    int idx, slot;
    oor = (caddr[k] >> (AW + 2)) != 0;
    idx = int'((caddr[k] >> 2) % DEPTH);
    exp_ack[k] = 1'b1;
    exp_err[k] = oor;
    if (oor) begin
      exp_rd[k] = 32'd0;
      rd_known[k] = 1'b1;
    end else begin
      slot = (idx < 8) ? idx : idx - (DEPTH - 16);
      if (cwe[k]) begin
        for (int n = 0; n < 4; n++) begin
          if (csel[k][n]) begin
            mm[k][slot][8*n +: 8] = cwdata[k][8*n +: 8];
            mk[k][slot][n] = 1'b1;
          end
        end
      end else begin
        rd_known[k] = (mk[k][slot] == 4'hF);
        exp_rd[k]   = mm[k][slot];
      end
    end
  endtask

  task automatic model_step(input int k);
    if (in_done[k]) begin
      in_done[k] = 1'b0;
      exp_ack[k] = 1'b0;
      exp_err[k] = 1'b0;
    end else begin
      if (remain[k] == 0 && req[k]) begin
        cwe[k] = we[k]; csel[k] = sel[k]; caddr[k] = addr[k]; cwdata[k] = wdata[k];
        remain[k] = wait_of(k) + 1;
      end
      if (remain[k] > 0) begin
        remain[k]--;
        if (remain[k] == 0) begin
          model_perform(k);
          in_done[k] = 1'b1;
        end
      end
    end
  endtask

  // ---------------- directed vectors for the 1-wait responder ----------------
  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int hc, lat;
    logic e;
    logic [31:0] r;

    vecs[0]  = '{"wr 10 full",   1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{"rd 10",        1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{"wr 10 lane1",  1'b1, 4'h2, 32'h0000_0010, 32'h0000_1200, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{"rd 10 lane1",  1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_12EF, 1'b0};
    vecs[4]  = '{"wr 10 sel0",   1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'hDEAD_12EF, 1'b0};
    vecs[5]  = '{"rd 13 offset", 1'b0, 4'hF, 32'h0000_0013, 32'h0,         32'hDEAD_12EF, 1'b0};
    vecs[6]  = '{"wr 0",         1'b1, 4'hF, 32'h0000_0000, 32'h0BAD_F00D, 32'hDEAD_12EF, 1'b0};
    vecs[7]  = '{"rd 4000 oor",  1'b0, 4'hF, 32'h0000_4000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[8]  = '{"wr 4000 oor",  1'b1, 4'hF, 32'h0000_4000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[9]  = '{"rd 0 intact",  1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[10] = '{"wr 3ffc last", 1'b1, 4'hF, 32'h0000_3FFC, 32'hA5A5_A5A5, 32'h0BAD_F00D, 1'b0};
    vecs[11] = '{"rd 3ffc last", 1'b0, 4'hF, 32'h0000_3FFC, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[12] = '{"rd high oor",  1'b0, 4'hF, 32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1};
    vecs[13] = '{"rd 10 again",  1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_12EF, 1'b0};

    // Reset held with a pending request: nothing may respond.
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      req[k] = 1'b1; we[k] = 1'b1; sel[k] = 4'hF; addr[k] = 32'h10; wdata[k] = 32'h1234_5678;
    end
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        check($sformatf("reset%0d hold", k),  32'(hold[k]), 32'd0);
        check($sformatf("reset%0d ack", k),   32'(ack[k]),  32'd0);
        check($sformatf("reset%0d err", k),   32'(err[k]),  32'd0);
        check($sformatf("reset%0d rdata", k), rdata[k],     32'd0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < N; k++) req[k] = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors on the 1-wait responder.
    for (int i = 0; i < 14; i++) begin
      access(1, vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].wdata, hc, lat, e, r);
      check({vecs[i].name, " hold cycles"}, 32'(hc), 32'd2);
      check({vecs[i].name, " latency"},     32'(lat), 32'd2);
      check({vecs[i].name, " err"},         32'(e), 32'(vecs[i].exp_err));
      check({vecs[i].name, " rdata"},       r, vecs[i].exp_rdata);
    end

    // Latency and hold length for 0 and 3 wait states, plus a data round trip.
    for (int k = 0; k < N; k += 2) begin
      access(k, 1'b1, 4'hF, 32'h10, 32'hC0DE_0000 + 32'(k), hc, lat, e, r);
      check($sformatf("w%0d wr hold cycles", wait_of(k)), 32'(hc), 32'(wait_of(k) + 1));
      check($sformatf("w%0d wr latency", wait_of(k)),     32'(lat), 32'(wait_of(k) + 1));
      access(k, 1'b0, 4'hF, 32'h10, 32'h0, hc, lat, e, r);
      check($sformatf("w%0d rd latency", wait_of(k)), 32'(lat), 32'(wait_of(k) + 1));
      check($sformatf("w%0d rd data", wait_of(k)),    r, 32'hC0DE_0000 + 32'(k));
      back_to_back(k);
    end

    // Reset during BUSY of a write: the write is lost.
    access(1, 1'b1, 4'hF, 32'h20, 32'h1111_1111, hc, lat, e, r);
    req[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; addr[1] = 32'h20; wdata[1] = 32'h2222_2222;
    @(posedge clk); #1;
    req[1] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("abort hold in reset", 32'(hold[1]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort ack", 32'(ack[1]), 32'd0);
    check("abort rdata", rdata[1], 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    access(1, 1'b0, 4'hF, 32'h20, 32'h0, hc, lat, e, r);
    check("abort mem kept", r, 32'h1111_1111);

    // Reset during DONE: the write committed on entering DONE is kept.
    req[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; addr[1] = 32'h24; wdata[1] = 32'h3333_3333;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    check("done-reset ack", 32'(ack[1]), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    access(1, 1'b0, 4'hF, 32'h24, 32'h0, hc, lat, e, r);
    check("done-reset mem", r, 32'h3333_3333);

    // Randomized traffic against the reference model; all responders idle.
    for (int k = 0; k < N; k++) begin
      remain[k] = 0; in_done[k] = 1'b0; exp_ack[k] = 1'b0; exp_err[k] = 1'b0;
      exp_rd[k] = 32'd0; rd_known[k] = 1'b0;
      for (int s = 0; s < 16; s++) begin
        mm[k][s] = 32'd0; mk[k][s] = 4'h0;
      end
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < N; k++) begin
        req[k]   = ($urandom_range(0, 2) != 0);
        we[k]    = 1'($urandom_range(0, 1));
        sel[k]   = 4'($urandom);
        addr[k]  = rand_addr();
        wdata[k] = $urandom;
      end
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        check($sformatf("rand%0d hold c%0d", k, cyc),
              32'(hold[k]), 32'(!in_done[k] && (remain[k] > 0 || req[k])));
        check($sformatf("rand%0d ack c%0d", k, cyc), 32'(ack[k]), 32'(exp_ack[k]));
        check($sformatf("rand%0d err c%0d", k, cyc), 32'(err[k]), 32'(exp_err[k]));
        if (rd_known[k]) check($sformatf("rand%0d rdata c%0d", k, cyc), rdata[k], exp_rd[k]);
      end
      for (int k = 0; k < N; k++) model_step(k);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rib_ram_resp.md
Name: rib_ram_resp

Overview:
- Memory-side responder for the RIB data-memory port driven by the core's execute stage.
- Accepts read and write requests, which may have byte-lane selects, into an internal word array.
- Inserts a programmable number of wait states and raises hold back to the core, which feeds `rib_hold_flag` into ctrl, until the access completes.
- Sits between the core's `rib_ram_*` outputs and the `rib_hold_flag` / `rib_ram_rdata` inputs.

Parameters:
- DEPTH, 4096, number of 32-bit words in the array. Must be a power of two, at least 2.
- WAIT_CYCLES, 1, BUSY cycles inserted per access. Range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled at the rising edge of clk.
- req_i  in  1  access request (`rib_ram_req`).
- we_i  in  1  1 = write, 0 = read (`rib_ram_we`).
- sel_i  in  4  byte-lane enables; bit n controls data bits [8n+7:8n] (`ram_sel`).
- addr_i  in  32  byte address (`rib_ram_wraddr`).
- wdata_i  in  32  write data (`rib_ram_wdata`).
- rdata_o  out  32  read data, registered (`rib_ram_rdata`).
- hold_o  out  1  stall request to the core (`rib_hold_flag`).
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse, out-of-range access.

Behaviour:
- States: IDLE, BUSY, DONE. A down-counter `cnt` (4 bits) counts the wait states.
- Reset (rst==0 at an edge):
  - state=IDLE, cnt=0, rdata_o=0, ack_o=0, err_o=0.
  - hold_o is forced to 0 while rst==0.
  - Array contents are not cleared.
- hold_o is combinational: hold_o = rst && ((state==IDLE && req_i) || state==BUSY). It is 0 in DONE.
- IDLE with req_i==1: accept the access.
  - Latch we_i, sel_i, addr_i, wdata_i.
  - If WAIT_CYCLES>0: go to BUSY and load cnt=WAIT_CYCLES-1.
  - If WAIT_CYCLES==0: go to DONE.
- IDLE with req_i==0: stay in IDLE. Outputs are unchanged except for the ack/err pulses described below.
- BUSY:
  - If cnt!=0: decrement cnt and stay in BUSY.
  - If cnt==0: go to DONE.
  - req_i and the other inputs are ignored; the latched copies are used.
- Entering DONE (same edge that sets state=DONE):
  - Word index `idx` = latched addr[log2(DEPTH)+1:2]. addr[1:0] is ignored.
  - The access is out of range when latched addr[31:log2(DEPTH)+2] != 0.
  - In range, read: rdata_o = mem[idx].
  - In range, write: for each n with sel[n]=1, mem[idx][8n+7:8n] = wdata[8n+7:8n]. Other lanes are unchanged. rdata_o keeps its previous value.
  - Out of range: no array write; rdata_o=0; err_o=1.
  - ack_o=1 in every case.
- DONE: always go to IDLE on the next edge. ack_o and err_o return to 0 on that edge.
- rdata_o holds its value until the next read completion or reset.
- Latency: from the accept edge, the DONE cycle is reached after WAIT_CYCLES+1 edges. hold_o is high for WAIT_CYCLES+1 cycles (accept cycle plus BUSY cycles).
- Back-to-back requests: req_i high in the cycle after DONE is a new access. Minimum spacing between accepts is WAIT_CYCLES+2 cycles.
- Boundary conditions:
  - sel_i==0 on a write: no array change; ack_o still pulses.
  - req_i dropped during BUSY: the access still completes using the latched values.
  - Reset during BUSY or DONE: abort immediately. Any write not yet performed is lost; a write already committed on entry to DONE is kept.
  - An access to the last word (idx=DEPTH-1) is in range.
  - An access to byte address DEPTH*4 is out of range.

Test Plan:
- Reset: hold rst=0 with req_i=1 for 3 cycles -> hold_o=0, ack_o=0, rdata_o=0, state IDLE.
- Write then read, WAIT_CYCLES=1:
  - Write 0xDEADBEEF to 0x10 with sel=4'hF -> hold_o high for 2 cycles; ack_o pulses in the 3rd cycle.
  - Read 0x10 -> rdata_o=0xDEADBEEF in the DONE cycle.
- Byte lanes: with 0xDEADBEEF at 0x10, write 0x00001200 with sel=4'b0010 -> read of 0x10 returns 0xDEAD12EF. A write with sel=0 leaves it unchanged and still pulses ack_o.
- Out of range, DEPTH=4096:
  - Read 0x4000 -> err_o=1, ack_o=1, rdata_o=0.
  - Write 0x4000 then read 0x0 -> 0x0 contents unchanged.
  - Read 0x3FFC -> err_o=0.
- WAIT_CYCLES=0 and WAIT_CYCLES=3: measure hold_o high cycles (1 and 4) and the accept-to-ack distance (1 and 4 edges). With req_i held high continuously, accepts occur every 2 and 5 cycles.
- Abort and protocol violation:
  - rst=0 during BUSY of a write to 0x20 -> mem[0x20] is unchanged afterwards; hold_o=0 while rst=0.
  - req_i dropped in BUSY -> the access still completes with ack_o=1.
